// File: rtl/axis_downsize_64_32.sv
// AXI-Stream 2*OUT_W -> OUT_W downsizer: low half first, tlast on final beat.
// Latency: beat 0 one cycle after accept; backpressure freezes state and outputs.
// Optional byte enables via AXIS_DOWNSIZE_KEEP_EN (empty high half skips beat 1).
module axis_downsize_64_32 #(
  parameter int OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*OUT_W-1:0]     s_tdata,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
`ifdef AXIS_DOWNSIZE_KEEP_EN
  input  logic [2*OUT_W/8-1:0]   s_tkeep,
`endif
  output logic                   s_tready,
  output logic [OUT_W-1:0]       m_tdata,
  output logic                   m_tlast,
  output logic                   m_tvalid,
`ifdef AXIS_DOWNSIZE_KEEP_EN
  output logic [OUT_W/8-1:0]     m_tkeep,
`endif
  input  logic                   m_tready
);

  localparam int BW = OUT_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*OUT_W-1:0]   buf_data_q, buf_data_d;
  logic                 buf_last_q, buf_last_d;
  logic                 ready_int;
  logic                 accept;
  logic                 lo_is_last;

`ifdef AXIS_DOWNSIZE_KEEP_EN
  logic [2*BW-1:0]      buf_keep_q, buf_keep_d;
  assign lo_is_last = (buf_keep_q[2*BW-1:BW] == '0);
`else
  assign lo_is_last = 1'b0;
`endif

  assign accept   = s_tvalid & ready_int;
  // Reset forces ready low so no word is taken while the buffer is being cleared.
  assign s_tready = ready_int & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_data_q <= '0;
      buf_last_q <= 1'b0;
`ifdef AXIS_DOWNSIZE_KEEP_EN
      buf_keep_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
`ifdef AXIS_DOWNSIZE_KEEP_EN
      buf_keep_q <= buf_keep_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_data_d = accept ? s_tdata : buf_data_q;
    buf_last_d = accept ? s_tlast : buf_last_q;
`ifdef AXIS_DOWNSIZE_KEEP_EN
    buf_keep_d = accept ? s_tkeep : buf_keep_q;
`endif
    case (state_q)
      IDLE: if (accept) state_d = LO;
      LO: begin
        if (m_tready) begin
          if (lo_is_last) state_d = accept ? LO : IDLE;
          else            state_d = HI;
        end
      end
      HI: if (m_tready) state_d = accept ? LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tdata   = buf_data_q[OUT_W-1:0];
    ready_int = 1'b0;
`ifdef AXIS_DOWNSIZE_KEEP_EN
    m_tkeep   = buf_keep_q[BW-1:0];
`endif
    case (state_q)
      IDLE: ready_int = 1'b1;
      LO: begin
        m_tvalid  = 1'b1;
        m_tlast   = lo_is_last & buf_last_q;
        ready_int = lo_is_last & m_tready;
      end
      HI: begin
        m_tvalid  = 1'b1;
        m_tdata   = buf_data_q[2*OUT_W-1:OUT_W];
        m_tlast   = buf_last_q;
        ready_int = m_tready;
`ifdef AXIS_DOWNSIZE_KEEP_EN
        m_tkeep   = buf_keep_q[2*BW-1:BW];
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axis_downsize_64_32.sv
// Scoreboard bench for axis_downsize_64_32: directed words, expected beats queued.
module tb_axis_downsize_64_32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
`ifdef AXIS_DOWNSIZE_KEEP_EN
  logic [7:0]  s_tkeep = 8'hFF;
  logic [3:0]  m_tkeep;
`endif

  axis_downsize_64_32 #(.OUT_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
`ifdef AXIS_DOWNSIZE_KEEP_EN
    .s_tkeep  (s_tkeep),
`endif
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
`ifdef AXIS_DOWNSIZE_KEEP_EN
    .m_tkeep  (m_tkeep),
`endif
    .m_tready (m_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } beat_t;

  beat_t exp_q[$];
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit rdy_rand = 1'b0;
  bit b2b_on = 1'b0;
  int b2b_cnt = 0;
  int b2b_first = 0;
  int b2b_lastc = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) m_tready = ($urandom_range(0, 1) == 1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_word(input logic [63:0] d, input logic l, input logic [7:0] k);
    beat_t b;
    if (k[7:4] == 4'h0) begin
      b.data = d[31:0]; b.last = l; b.keep = k[3:0]; exp_q.push_back(b);
    end else begin
      b.data = d[31:0]; b.last = 1'b0; b.keep = k[3:0]; exp_q.push_back(b);
      b.data = d[63:32]; b.last = l; b.keep = k[7:4]; exp_q.push_back(b);
    end
  endtask

  // Drives one word and returns at posedge+1 after its acceptance edge.
  task automatic send(input logic [63:0] d, input logic l, input logic [7:0] k);
    int n = 0;
    push_word(d, l, k);
    s_tdata = d;
    s_tlast = l;
`ifdef AXIS_DOWNSIZE_KEEP_EN
    s_tkeep = k;
`endif
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {63'd0, s_tready}, 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_data", 64'(m_tdata), 64'(prev_data));
        chk("hold_last", 64'(m_tlast), 64'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_beat: got %h, expected no beat (cycle %0d)", m_tdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_tdata), 64'(e.data));
          chk("beat_last", 64'(m_tlast), 64'(e.last));
`ifdef AXIS_DOWNSIZE_KEEP_EN
          chk("beat_keep", 64'(m_tkeep), 64'(e.keep));
`endif
          if (b2b_on) begin
            if (b2b_cnt == 0) b2b_first = cyc;
            b2b_cnt++;
            b2b_lastc = cyc;
          end
        end
      end
      prev_hold = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
    end
  end

  initial begin
    int acc[8];
    logic [63:0] d;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("post_rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("post_rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("post_rst_s_tready", 64'(s_tready), 64'd1);
    @(posedge clk); #1;

    // Single word, exact timing
    m_tready = 1'b1;
    send(64'h11112222_33334444, 1'b1, 8'hFF);
    @(negedge clk);
    chk("single_b0_vld", 64'(m_tvalid), 64'd1);
    chk("single_b0_dat", 64'(m_tdata), 64'h33334444);
    chk("single_b0_last", 64'(m_tlast), 64'd0);
    @(negedge clk);
    chk("single_b1_dat", 64'(m_tdata), 64'h11112222);
    chk("single_b1_last", 64'(m_tlast), 64'd1);
    @(negedge clk);
    chk("single_idle_vld", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;

    // Back-to-back: accepts every 2nd cycle, 16 contiguous beats
    b2b_on = 1'b1;
    b2b_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send({32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)}, (i == 7), 8'hFF);
      acc[i] = acc_cyc;
    end
    drain();
    @(negedge clk);
    b2b_on = 1'b0;
    for (int i = 1; i < 8; i++) chk("b2b_accept_gap", 64'(acc[i] - acc[i-1]), 64'd2);
    chk("b2b_beat_count", 64'(b2b_cnt), 64'd16);
    chk("b2b_contiguous", 64'(b2b_lastc - b2b_first), 64'd15);
    @(posedge clk); #1;

    // Stall in HI with next word waiting
    m_tready = 1'b0;
    send(64'h0123_4567_89AB_CDEF, 1'b0, 8'hFF);
    push_word(64'hFEDC_BA98_7654_3210, 1'b1, 8'hFF);
    s_tdata = 64'hFEDC_BA98_7654_3210;
    s_tlast = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    chk("stall_lo_rdy", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hi_rdy", 64'(s_tready), 64'd0);
      chk("stall_hi_dat", 64'(m_tdata), 64'h0123_4567);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    @(negedge clk);
    chk("stall_release_rdy", 64'(s_tready), 64'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    drain();
    @(posedge clk); #1;

    // Reset while in LO: held word must vanish
    m_tready = 1'b0;
    send(64'hBAD0_BAD0_5555_AAAA, 1'b1, 8'hFF);
    @(negedge clk);
    chk("rst_mid_in_lo", 64'(m_tvalid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    chk("rst_mid_vld", 64'(m_tvalid), 64'd0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    send(64'h7777_8888_9999_0000, 1'b1, 8'hFF);
    drain();
    @(posedge clk); #1;

`ifdef AXIS_DOWNSIZE_KEEP_EN
    // Empty high keep half: single beat, back to idle
    m_tready = 1'b1;
    send(64'hDEADBEEF_CAFEF00D, 1'b1, 8'h0F);
    @(negedge clk);
    chk("keep_vld", 64'(m_tvalid), 64'd1);
    chk("keep_dat", 64'(m_tdata), 64'hCAFEF00D);
    chk("keep_keep", 64'(m_tkeep), 64'hF);
    chk("keep_last", 64'(m_tlast), 64'd1);
    @(negedge clk);
    chk("keep_idle", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
`endif

    // Random backpressure over 1000 words
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      d = {$urandom, $urandom};
      send(d, ($urandom_range(0, 3) == 0), 8'hFF);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    @(posedge clk); #2;
    rdy_rand = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
